cfg_chain_loader: RTL and testbench

CFG_CHAIN_LOADER -- requirements
Module: cfg_chain_loader

---
 rtl/cfg_chain_pkg.sv | 18 +
 rtl/cfg_word_serdes.sv | 68 ++++++
 rtl/cfg_chain_loader.sv | 121 ++++++++++++
 tb/tb_cfg_chain_loader.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_chain_pkg.sv
// Shared types and helpers for the configuration-chain loader.
// Holds the loader state encoding and the counter-width helper used by loader and serdes.
package cfg_chain_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_STALL,
        ST_DONE
    } state_t;

    // Bits needed to count from 0 up to maxVal inclusive, never less than 1.
    function automatic int cnt_width(input int maxVal);
        return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
    endfunction

endpackage

// File: rtl/cfg_word_serdes.sv
// Word-level serializer/deserializer for the config chain: parallel-in/serial-out toward
// the chain head, serial-in/parallel-out from the chain tail, plus the word-bit counter.
module cfg_word_serdes
    import cfg_chain_pkg::*;
#(
    parameter int WORD_W = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              load_i,
    input  logic [WORD_W-1:0] data_i,
    input  logic              shift_i,
    input  logic              last_i,
    input  logic              tail_i,
    output logic              head_o,
    output logic              word_last_o,
    output logic [WORD_W-1:0] word_o
);

    localparam int WC_W = cnt_width(WORD_W - 1);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(WORD_W - 1);

    logic [WORD_W-1:0] sh_q, sh_d;
    logic [WORD_W-1:0] rb_q, rb_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [WORD_W-1:0] rbShifted;
    logic [WC_W-1:0]   wcnt_q, wcnt_d;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sh_q   <= '0;
            rb_q   <= '0;
            word_q <= '0;
            wcnt_q <= '0;
        end else begin
            sh_q   <= sh_d;
            rb_q   <= rb_d;
            word_q <= word_d;
            wcnt_q <= wcnt_d;
        end
    end

    // A short final word is left-aligned so the first tail bit always lands in the MSB.
    always_comb begin
        sh_d      = sh_q;
        rb_d      = rb_q;
        word_d    = word_q;
        wcnt_d    = wcnt_q;
        rbShifted = (rb_q << 1) | WORD_W'(tail_i);
        if (load_i) begin
            sh_d   = data_i;
            rb_d   = '0;
            wcnt_d = '0;
        end else if (shift_i) begin
            sh_d   = sh_q << 1;
            rb_d   = rbShifted;
            wcnt_d = wcnt_q + WC_W'(1);
            if (last_i) begin
                word_d = rbShifted << (WC_LAST - wcnt_q);
            end
        end
    end

    assign head_o      = sh_q[WORD_W-1];
    assign word_last_o = (wcnt_q == WC_LAST);
    assign word_o      = word_q;

endmodule

// File: rtl/cfg_chain_loader.sv
// Streams bitstream words serially into a configuration chain while capturing the old
// chain contents from the tail as readback words.
module cfg_chain_loader
    import cfg_chain_pkg::*;
#(
    parameter int CHAIN_LEN = 1024,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              chain_shift_en,
    output logic [WORD_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
    output logic              done
);

    localparam int BC_W = cnt_width(CHAIN_LEN);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(CHAIN_LEN - 1);

    state_t          state_q, state_d;
    logic [BC_W-1:0] bitCnt_q, bitCnt_d;
    logic            mValid_q, mValid_d;

    logic sReadyC;
    logic acceptC;
    logic shiftC;
    logic chainLast;
    logic wordLast;
    logic headBit;

    assign chainLast = (bitCnt_q == BC_LAST);

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state_q  <= ST_IDLE;
            bitCnt_q <= '0;
            mValid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitCnt_q <= bitCnt_d;
            mValid_q <= mValid_d;
        end
    end

    // A new word may be taken in the same cycle the pending readback word is consumed,
    // which keeps throughput at one LOAD cycle per word without backpressure.
    always_comb begin
        state_d  = state_q;
        bitCnt_d = bitCnt_q;
        mValid_d = mValid_q;
        sReadyC  = 1'b0;
        acceptC  = 1'b0;
        shiftC   = 1'b0;
        if (mValid_q && m_ready) begin
            mValid_d = 1'b0;
        end
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d  = ST_LOAD;
                    bitCnt_d = '0;
                end
            end
            ST_LOAD: begin
                sReadyC = !mValid_q || m_ready;
                if (s_valid && sReadyC) begin
                    acceptC = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shiftC   = 1'b1;
                bitCnt_d = bitCnt_q + BC_W'(1);
                if (wordLast || chainLast) begin
                    mValid_d = 1'b1;
                    state_d  = chainLast ? ST_STALL : ST_LOAD;
                end
            end
            ST_STALL: begin
                if (!mValid_q || m_ready) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    cfg_word_serdes #(
        .WORD_W (WORD_W)
    ) u_serdes (
        .clk_i       (prog_clk),
        .reset_i     (prog_reset),
        .load_i      (acceptC),
        .data_i      (s_data),
        .shift_i     (shiftC),
        .last_i      (wordLast || chainLast),
        .tail_i      (ccff_tail),
        .head_o      (headBit),
        .word_last_o (wordLast),
        .word_o      (m_data)
    );

    // Reset gates the shift strobe directly so an abort never costs one extra chain pulse.
    assign chain_shift_en = shiftC && !prog_reset;
    assign ccff_head      = chain_shift_en && headBit;
    assign s_ready        = sReadyC;
    assign m_valid        = mValid_q;
    assign busy           = (state_q == ST_LOAD) || (state_q == ST_SHIFT) || (state_q == ST_STALL);
    assign done           = (state_q == ST_DONE);

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Self-checking bench: a 16-bit and a 12-bit chain loader, each driving a behavioural chain.
// Expected chain contents and readback words come from the bit-stream arithmetic, not the RTL.
module tb_cfg_chain_loader;

    localparam int WORD_W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        progReset [2];
    logic        tbStart   [2];
    logic [7:0]  sData     [2];
    logic        sValid    [2];
    logic        sReady    [2];
    logic        ccffHead  [2];
    logic        ccffTail  [2];
    logic        shiftEn   [2];
    logic [7:0]  mData     [2];
    logic        mValid    [2];
    logic        mReady    [2];
    logic        busyOut   [2];
    logic        doneOut   [2];

    logic [15:0] chain      [2];
    logic [15:0] preloadVal [2];
    logic        preloadEn  [2];
    int          shifts     [2];
    int          rbn        [2];
    logic [7:0]  rb         [2][4];

    int checks = 0;
    int errors = 0;

    cfg_chain_loader #(.CHAIN_LEN(16), .WORD_W(WORD_W)) dut16 (
        .prog_clk(clk), .prog_reset(progReset[0]), .start(tbStart[0]),
        .s_data(sData[0]), .s_valid(sValid[0]), .s_ready(sReady[0]),
        .ccff_head(ccffHead[0]), .ccff_tail(ccffTail[0]), .chain_shift_en(shiftEn[0]),
        .m_data(mData[0]), .m_valid(mValid[0]), .m_ready(mReady[0]),
        .busy(busyOut[0]), .done(doneOut[0])
    );

    cfg_chain_loader #(.CHAIN_LEN(12), .WORD_W(WORD_W)) dut12 (
        .prog_clk(clk), .prog_reset(progReset[1]), .start(tbStart[1]),
        .s_data(sData[1]), .s_valid(sValid[1]), .s_ready(sReady[1]),
        .ccff_head(ccffHead[1]), .ccff_tail(ccffTail[1]), .chain_shift_en(shiftEn[1]),
        .m_data(mData[1]), .m_valid(mValid[1]), .m_ready(mReady[1]),
        .busy(busyOut[1]), .done(doneOut[1])
    );

    assign ccffTail[0] = chain[0][15];
    assign ccffTail[1] = chain[1][11];

    // Behavioural chains (shift in at bit 0, tail at the top bit) plus a readback scoreboard.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (preloadEn[d]) begin
                chain[d]  <= preloadVal[d];
                shifts[d] <= 0;
                rbn[d]    <= 0;
            end else begin
                if (shiftEn[d] === 1'b1) begin
                    chain[d]  <= {chain[d][14:0], ccffHead[d]};
                    shifts[d] <= shifts[d] + 1;
                end
                if (mValid[d] === 1'b1 && mReady[d] === 1'b1) begin
                    if (rbn[d] < 4) rb[d][rbn[d]] <= mData[d];
                    rbn[d] <= rbn[d] + 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic preloadChain(input int d, input logic [15:0] v);
        preloadVal[d] = v;
        preloadEn[d]  = 1'b1;
        tick();
        preloadEn[d]  = 1'b0;
    endtask

    task automatic pulseStart(input int d);
        tbStart[d] = 1'b1;
        tick();
        tbStart[d] = 1'b0;
    endtask

    task automatic sendWord(input int d, input logic [7:0] w);
        int n = 0;
        sData[d]  = w;
        sValid[d] = 1'b1;
        while (sReady[d] !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        checkOutput($sformatf("d%0d_s_ready_wait", d), 32'(n < 200), 32'd1);
        tick();
        sValid[d] = 1'b0;
        sData[d]  = 8'($urandom);
    endtask

    task automatic waitShifts(input int d, input int target);
        int n = 0;
        while (shifts[d] < target && n < 100) begin
            tick();
            n++;
        end
        checkOutput($sformatf("d%0d_shift_wait", d), 32'(n < 100), 32'd1);
    endtask

    task automatic waitDone(input int d);
        int n = 0;
        while (doneOut[d] !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        checkOutput($sformatf("d%0d_done_reached", d), 32'(doneOut[d]), 32'd1);
    endtask

    // mode 0: plain, 1: start pulse during SHIFT, 2: starved input, 3: readback backpressure
    task automatic applyStimulus(input int d, input logic [15:0] oldIn, input logic [7:0] w0,
                                 input logic [7:0] w1, input int mode);
        int          len;
        logic [15:0] mask, oldVal, aligned, stream, expChain, snap;
        logic [7:0]  hold;
        logic        bad;
        len      = (d == 0) ? 16 : 12;
        mask     = (d == 0) ? 16'hFFFF : 16'h0FFF;
        oldVal   = oldIn & mask;
        aligned  = oldVal << (16 - len);
        stream   = {w0, w1};
        expChain = stream >> (16 - len);
        $display("[TB] load d=%0d mode=%0d old=0x%0h words=0x%0h 0x%0h", d, mode, oldVal, w0, w1);

        preloadChain(d, oldVal);
        mReady[d] = (mode != 3);
        pulseStart(d);
        checkOutput($sformatf("d%0d_busy_after_start", d), 32'(busyOut[d]), 32'd1);
        checkOutput($sformatf("d%0d_done_after_start", d), 32'(doneOut[d]), 32'd0);
        sendWord(d, w0);
        if (mode == 1) begin
            tbStart[d] = 1'b1;
            tick();
            tbStart[d] = 1'b0;
            checkOutput($sformatf("d%0d_busy_start_ignored", d), 32'(busyOut[d]), 32'd1);
        end
        if (mode >= 2) begin
            waitShifts(d, 8);
        end
        if (mode == 2) begin
            snap = chain[d];
            bad  = 1'b0;
            repeat (10) begin
                tick();
                if (shiftEn[d] !== 1'b0) bad = 1'b1;
            end
            checkOutput($sformatf("d%0d_starve_no_shift", d), 32'(bad), 32'd0);
            checkOutput($sformatf("d%0d_starve_chain_hold", d), 32'(chain[d]), 32'(snap));
        end
        if (mode == 3) begin
            checkOutput($sformatf("d%0d_bp_m_valid", d), 32'(mValid[d]), 32'd1);
            checkOutput($sformatf("d%0d_bp_m_data", d), 32'(mData[d]), 32'(aligned[15:8]));
            sData[d]  = w1;
            sValid[d] = 1'b1;
            hold      = mData[d];
            bad       = 1'b0;
            repeat (20) begin
                tick();
                if (sReady[d] !== 1'b0 || shiftEn[d] !== 1'b0 || mData[d] !== hold) bad = 1'b1;
            end
            checkOutput($sformatf("d%0d_bp_stall", d), 32'(bad), 32'd0);
            mReady[d] = 1'b1;
            #1;
            checkOutput($sformatf("d%0d_bp_resume", d), 32'(sReady[d]), 32'd1);
        end
        sendWord(d, w1);
        waitDone(d);
        checkOutput($sformatf("d%0d_chain", d), 32'(chain[d] & mask), 32'(expChain));
        checkOutput($sformatf("d%0d_shift_count", d), 32'(shifts[d]), 32'(len));
        checkOutput($sformatf("d%0d_rb_count", d), 32'(rbn[d]), 32'd2);
        checkOutput($sformatf("d%0d_rb_word0", d), 32'(rb[d][0]), 32'(aligned[15:8]));
        checkOutput($sformatf("d%0d_rb_word1", d), 32'(rb[d][1]), 32'(aligned[7:0]));
        checkOutput($sformatf("d%0d_done_s_ready", d), 32'(sReady[d]), 32'd0);
        checkOutput($sformatf("d%0d_done_busy", d), 32'(busyOut[d]), 32'd0);
    endtask

    task automatic checkIdleOutputs(input int d, input string tag);
        checkOutput($sformatf("%s_s_ready", tag), 32'(sReady[d]), 32'd0);
        checkOutput($sformatf("%s_shift_en", tag), 32'(shiftEn[d]), 32'd0);
        checkOutput($sformatf("%s_head", tag), 32'(ccffHead[d]), 32'd0);
        checkOutput($sformatf("%s_m_valid", tag), 32'(mValid[d]), 32'd0);
        checkOutput($sformatf("%s_m_data", tag), 32'(mData[d]), 32'd0);
        checkOutput($sformatf("%s_busy", tag), 32'(busyOut[d]), 32'd0);
        checkOutput($sformatf("%s_done", tag), 32'(doneOut[d]), 32'd0);
    endtask

    initial begin
        logic [15:0] oldVal;
        logic [7:0]  w;
        for (int d = 0; d < 2; d++) begin
            progReset[d] = 1'b1;
            tbStart[d]   = 1'b0;
            sData[d]     = '0;
            sValid[d]    = 1'b0;
            mReady[d]    = 1'b1;
            preloadEn[d] = 1'b0;
            preloadVal[d] = '0;
        end
        tick();
        tick();
        checkIdleOutputs(0, "reset16");
        checkIdleOutputs(1, "reset12");
        progReset[0] = 1'b0;
        progReset[1] = 1'b0;
        tick();

        applyStimulus(0, 16'hA5C3, 8'h12, 8'h34, 0);
        applyStimulus(1, 16'($urandom), 8'hFF, 8'hAB, 0);
        checkOutput("d1_partial_chain_fixed", 32'(chain[1][11:0]), 32'h0FFA);
        applyStimulus(0, 16'($urandom), 8'($urandom), 8'($urandom), 3);
        applyStimulus(0, 16'($urandom), 8'($urandom), 8'($urandom), 2);
        applyStimulus(0, 16'($urandom), 8'($urandom), 8'($urandom), 1);
        applyStimulus(0, 16'($urandom), 8'($urandom), 8'($urandom), 0);

        // Abort after exactly three shifts of the first word.
        oldVal = 16'($urandom);
        w      = 8'($urandom);
        preloadChain(0, oldVal);
        mReady[0] = 1'b1;
        pulseStart(0);
        sendWord(0, w);
        repeat (3) tick();
        checkOutput("rst_pre_shifts", 32'(shifts[0]), 32'd3);
        progReset[0] = 1'b1;
        #1;
        checkOutput("rst_gate_shift_en", 32'(shiftEn[0]), 32'd0);
        tick();
        progReset[0] = 1'b0;
        checkIdleOutputs(0, "rst_mid");
        checkOutput("rst_mid_chain", 32'(chain[0]), 32'({oldVal[12:0], w[7:5]}));
        checkOutput("rst_mid_shifts", 32'(shifts[0]), 32'd3);
        tick();

        for (int i = 0; i < 8; i++) begin
            applyStimulus(i % 2, 16'($urandom), 8'($urandom), 8'($urandom),
                          int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
